// File: rtl/dna_search_axil_engine.sv
// AXI4-Lite DNA search engine: a 2-bit-per-base sequence buffer and a search pattern, scanned one
// base per clock to count (overlapping) pattern occurrences and locate the first one.
module dna_search_axil_engine #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 9,
  parameter int unsigned SEQ_WORDS          = 64
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              irq
);

  localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW        = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned BPW       = DW / 2;
  localparam int unsigned ADDR_LSB  = $clog2(DW / 8);
  localparam int unsigned BASE_BITS = $clog2(BPW);
  localparam int unsigned WORD_BITS = $clog2(SEQ_WORDS);
  localparam int unsigned MAX_LEN   = SEQ_WORDS * BPW;

  typedef enum logic [0:0] {StIdle, StScan} state_e;
  state_e state_q, state_d;

  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    bresp_q;
  logic [DW-1:0] rdata_q, rd_val;
  logic          irq_en_q, done_q, found_q, err_q, busy;
  logic [6:0]    pat_len_q, new_pat_len;
  logic [DW-1:0] pattern_q, seq_len_q, match_count_q, first_match_q, win_q, scan_idx_q;
  logic [DW-1:0] seq_mem [SEQ_WORDS];

  logic [AW-1:0] widx, ridx, woff, roff;
  logic          wr_fire, rd_fire, wr_seq, rd_seq, wr_err, start_cmd, abort_cmd, start_bad;
  logic          last, hit;
  logic [DW-1:0] cur_shift, win_next, aligned, pat_mask;
  logic [7:0]    shamt;
  logic          unused;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    for (int b = 0; b < DW / 8; b++) res[8*b +: 8] = strb[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  assign widx    = S_AXI_AWADDR >> ADDR_LSB;
  assign ridx    = S_AXI_ARADDR >> ADDR_LSB;
  assign woff    = widx - AW'(8);
  assign roff    = ridx - AW'(8);
  assign wr_seq  = (widx >= AW'(8)) && (widx < AW'(8 + SEQ_WORDS));
  assign rd_seq  = (ridx >= AW'(8)) && (ridx < AW'(8 + SEQ_WORDS));
  assign wr_fire = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = arready_q && S_AXI_ARVALID;
  assign wr_err  = busy && (widx == AW'(2) || widx == AW'(3) || wr_seq);

  // START sees the PAT_LEN carried by the same CTRL write.
  assign new_pat_len = S_AXI_WSTRB[1] ? S_AXI_WDATA[14:8] : pat_len_q;
  assign start_cmd   = wr_fire && widx == '0 && S_AXI_WSTRB[0] && S_AXI_WDATA[0] && !busy;
  assign abort_cmd   = wr_fire && widx == '0 && S_AXI_WSTRB[0] && S_AXI_WDATA[1] && busy;
  assign start_bad   = (new_pat_len == 7'd0) || (new_pat_len > 7'(BPW)) ||
                       (seq_len_q > DW'(MAX_LEN));

  // Window holds the newest base in the top slot; the newest PAT_LEN bases are shifted down so
  // the oldest of them lines up with pattern base 0.
  assign cur_shift = seq_mem[scan_idx_q[BASE_BITS +: WORD_BITS]] >> {scan_idx_q[BASE_BITS-1:0], 1'b0};
  assign win_next  = {cur_shift[1:0], win_q[DW-1:2]};
  assign shamt     = 8'(BPW) - {1'b0, pat_len_q};
  assign aligned   = win_next >> {shamt, 1'b0};
  assign last      = scan_idx_q == seq_len_q - DW'(1);
  assign hit       = busy && !abort_cmd && (scan_idx_q + DW'(1) >= DW'(pat_len_q)) &&
                     ((aligned & pat_mask) == (pattern_q & pat_mask));

  always_comb begin
    pat_mask = '0;
    for (int k = 0; k < BPW; k++) if (k < int'(pat_len_q)) pat_mask[2*k +: 2] = 2'b11;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) state_q <= StIdle;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_cmd && !start_bad && seq_len_q != '0) state_d = StScan;
      StScan: if (abort_cmd || last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StScan);
    irq  = done_q & irq_en_q;
  end

  always_comb begin
    rd_val = '0;
    if (ridx < AW'(8)) begin
      case (ridx[2:0])
        3'd0: begin rd_val[2] = irq_en_q; rd_val[14:8] = pat_len_q; end
        3'd1: rd_val[3:0] = {err_q, found_q, done_q, busy};
        3'd2: rd_val = pattern_q;
        3'd3: rd_val = seq_len_q;
        3'd4: rd_val = match_count_q;
        3'd5: rd_val = first_match_q;
        default: rd_val = '0;
      endcase
    end else if (rd_seq) begin
      rd_val = seq_mem[roff[WORD_BITS-1:0]];
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      awready_q     <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      irq_en_q      <= 1'b0;
      pat_len_q     <= '0;
      pattern_q     <= '0;
      seq_len_q     <= '0;
      match_count_q <= '0;
      first_match_q <= '1;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      err_q         <= 1'b0;
      win_q         <= '0;
      scan_idx_q    <= '0;
    end else begin
      awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      if (wr_fire && !wr_err) begin
        if (widx == '0) begin
          if (S_AXI_WSTRB[0]) irq_en_q <= S_AXI_WDATA[2];
          if (S_AXI_WSTRB[1] && !busy) pat_len_q <= S_AXI_WDATA[14:8];
        end
        if (widx == AW'(2)) pattern_q <= apply_strb(pattern_q, S_AXI_WDATA, S_AXI_WSTRB);
        if (widx == AW'(3)) seq_len_q <= apply_strb(seq_len_q, S_AXI_WDATA, S_AXI_WSTRB);
      end

      if (start_cmd) begin
        done_q        <= start_bad || seq_len_q == '0;
        err_q         <= start_bad;
        found_q       <= 1'b0;
        match_count_q <= '0;
        first_match_q <= '1;
        scan_idx_q    <= '0;
        win_q         <= '0;
      end else if (busy && !abort_cmd) begin
        scan_idx_q <= scan_idx_q + DW'(1);
        win_q      <= win_next;
        if (hit) begin
          if (match_count_q != '1) match_count_q <= match_count_q + DW'(1);
          if (!found_q) begin
            found_q       <= 1'b1;
            first_match_q <= scan_idx_q - DW'(pat_len_q) + DW'(1);
          end
        end
        if (last) done_q <= 1'b1;
      end
    end
  end

  // Sequence storage carries no reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_fire && wr_seq && !busy)
      seq_mem[woff[WORD_BITS-1:0]] <=
        apply_strb(seq_mem[woff[WORD_BITS-1:0]], S_AXI_WDATA, S_AXI_WSTRB);
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, woff[AW-1:WORD_BITS], roff[AW-1:WORD_BITS]};

endmodule

// File: tb/tb_dna_search_axil_engine.sv
// Bench for dna_search_axil_engine: directed register/protocol steps plus randomized scans
// checked against a brute-force substring-count model.
module tb_dna_search_axil_engine;
  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int SW  = 64;
  localparam int BPW = 16;
  localparam logic [AW-1:0] A_CTRL = 9'd0,  A_STAT = 9'd4,  A_PAT = 9'd8;
  localparam logic [AW-1:0] A_LEN  = 9'd12, A_MC   = 9'd16, A_FM  = 9'd20;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, irq;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned wr_cyc = 0;
  int unsigned irq_rise_cyc = 0;
  logic        irq_prev = 1'b0;
  logic [31:0] mem [SW];

  dna_search_axil_engine #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .SEQ_WORDS(SW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (irq && !irq_prev) irq_rise_cyc = cyc;
    irq_prev = irq;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] a_seq(input int w);
    return AW'((8 + w) * 4);
  endfunction

  function automatic logic [1:0] base_at(input int i);
    logic [31:0] w;
    w = mem[i / BPW];
    return w[2*(i % BPW) +: 2];
  endfunction

  // Brute force: try every start position and compare pattern bases one by one.
  task automatic model(input int sl, input int pl, input logic [31:0] pat,
                       output int cnt, output logic [31:0] first);
    cnt = 0;
    first = 32'hFFFF_FFFF;
    for (int s = 0; s + pl <= sl; s++) begin
      bit ok = 1'b1;
      for (int k = 0; k < pl; k++) if (base_at(s + k) != pat[2*k +: 2]) ok = 1'b0;
      if (ok) begin
        if (cnt == 0) first = 32'(s);
        cnt++;
      end
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) check("aw_timeout", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    wr_cyc = cyc;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    if (!bvalid) check("b_timeout", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) check("ar_timeout", {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    if (!rvalid) check("r_timeout", {31'b0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(tag, d, exp);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!irq && n < budget);
    if (!irq) check("done_timeout", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d, first, pat, r0;
    logic [1:0]  resp;
    int          cnt, sl, pl, pos, acc, chg;

    rst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0; awvalid = 1'b0;
    wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {22'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp, irq},
          32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      axi_read(AW'(i * 4), d, resp);
      check($sformatf("reset_reg%0d", i), d, (i == 5) ? 32'hFFFF_FFFF : 32'd0);
      check($sformatf("reset_rresp%0d", i), {30'b0, resp}, 32'd0);
    end
    axi_write(A_PAT, 32'h0, 4'hF, resp);
    check("reset_bresp", {30'b0, resp}, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);

    for (int w = 0; w < SW; w++) begin
      mem[w] = $urandom;
      wr(a_seq(w), mem[w]);
    end

    // ACGT x4, pattern ACG
    mem[0] = 32'hE4E4_E4E4;
    wr(a_seq(0), mem[0]);
    wr(A_LEN, 32'd16);
    wr(A_PAT, 32'h24);
    wr(A_CTRL, 32'h0305);
    wait_done(200);
    check("acgt_busy_len", irq_rise_cyc - wr_cyc, 32'd16);
    model(16, 3, 32'h24, cnt, first);
    rd_chk("acgt_count", A_MC, 32'(cnt));
    rd_chk("acgt_first", A_FM, first);
    rd_chk("acgt_status", A_STAT, 32'h6);
    check("acgt_irq", {31'b0, irq}, 32'd1);

    // All A, pattern AA: overlapping matches
    mem[0] = 32'h0;
    wr(a_seq(0), mem[0]);
    wr(A_PAT, 32'h0);
    wr(A_CTRL, 32'h0205);
    wait_done(200);
    model(16, 2, 32'h0, cnt, first);
    rd_chk("allA_count", A_MC, 32'(cnt));
    rd_chk("allA_first", A_FM, first);

    // Long scan: writes while busy, then abort
    wr(A_LEN, 32'd1024);
    wr(A_CTRL, 32'h0205);
    axi_write(A_PAT, 32'hFF, 4'hF, resp);
    check("busy_pat_slverr", {30'b0, resp}, 32'd2);
    rd_chk("busy_pat_kept", A_PAT, 32'h0);
    axi_write(a_seq(3), 32'h1, 4'hF, resp);
    check("busy_seq_slverr", {30'b0, resp}, 32'd2);
    axi_write(A_CTRL, 32'h0205, 4'hF, resp);
    check("busy_start_okay", {30'b0, resp}, 32'd0);
    axi_write(A_CTRL, 32'h6, 4'h1, resp);
    check("abort_okay", {30'b0, resp}, 32'd0);
    rd_chk("abort_status", A_STAT, 32'h4);
    check("abort_irq", {31'b0, irq}, 32'd0);
    rd_chk("abort_seq_kept", a_seq(3), mem[3]);

    // Rejected starts
    wr(A_LEN, 32'd16);
    wr(A_CTRL, 32'h0005);
    rd_chk("rej_patlen0", A_STAT, 32'hA);
    wr(A_CTRL, 32'h1105);
    rd_chk("rej_patlen17", A_STAT, 32'hA);
    wr(A_LEN, 32'd1025);
    wr(A_CTRL, 32'h0205);
    rd_chk("rej_seqlen", A_STAT, 32'hA);
    check("rej_irq", {31'b0, irq}, 32'd1);
    wr(A_LEN, 32'd2);
    wr(A_CTRL, 32'h0305);
    wait_done(50);
    rd_chk("short_count", A_MC, 32'd0);
    rd_chk("short_first", A_FM, 32'hFFFF_FFFF);
    rd_chk("short_status", A_STAT, 32'h2);

    // Randomized scans
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 8; w++) begin
        mem[w] = $urandom;
        wr(a_seq(w), mem[w]);
      end
      sl = (r == 1) ? 0 : $urandom_range(1, 128);
      pl = (r == 0) ? BPW : $urandom_range(1, 6);
      pat = (pl < BPW) ? ($urandom << (2 * pl)) : 32'h0;
      if (sl >= pl) begin
        pos = $urandom_range(0, sl - pl);
        for (int k = 0; k < pl; k++) pat[2*k +: 2] = base_at(pos + k);
      end else begin
        pat = $urandom;
      end
      wr(A_PAT, pat);
      wr(A_LEN, 32'(sl));
      wr(A_CTRL, (32'(pl) << 8) | 32'h5);
      wait_done(300);
      if (sl > 0) check($sformatf("rnd%0d_busy_len", r), irq_rise_cyc - wr_cyc, 32'(sl));
      model(sl, pl, pat, cnt, first);
      rd_chk($sformatf("rnd%0d_count", r), A_MC, 32'(cnt));
      rd_chk($sformatf("rnd%0d_first", r), A_FM, first);
      rd_chk($sformatf("rnd%0d_status", r), A_STAT, (cnt > 0) ? 32'h6 : 32'h2);
    end

    // Byte strobes and unmapped space
    wr(A_PAT, 32'h1234);
    axi_write(A_PAT, 32'hAAAA_BBCC, 4'b0010, resp);
    rd_chk("strb_pattern", A_PAT, (32'h1234 & ~32'hFF00) | 32'hBB00);
    axi_write(AW'(6 * 4), 32'hDEAD_BEEF, 4'hF, resp);
    check("rsvd_bresp", {30'b0, resp}, 32'd0);
    rd_chk("rsvd_read", AW'(6 * 4), 32'd0);
    rd_chk("beyond_read", a_seq(SW), 32'd0);

    // Write-response backpressure
    awaddr = A_PAT; wdata = 32'h5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b0; acc = 0;
    repeat (12) begin @(negedge clk); if (awready) acc++; end
    check("bp_aw_accepts", 32'(acc), 32'd1);
    check("bp_bvalid_held", {31'b0, bvalid}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("bp_bvalid_drop", {31'b0, bvalid}, 32'd0);
    @(posedge clk); #1;

    // Read-data backpressure
    araddr = A_PAT; arvalid = 1'b1; rready = 1'b0; acc = 0; chg = 0; r0 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (arready) acc++;
      if (i == 3) r0 = rdata;
      if (i > 3 && rdata !== r0) chg++;
    end
    check("bp_ar_accepts", 32'(acc), 32'd1);
    check("bp_rvalid_held", {31'b0, rvalid}, 32'd1);
    check("bp_rdata_stable", 32'(chg), 32'd0);
    check("bp_rdata", r0, 32'h5A5A);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Asynchronous reset in the middle of a scan with a read response pending
    wr(A_LEN, 32'd1024);
    wr(A_CTRL, 32'h0205);
    araddr = A_LEN; arvalid = 1'b1; rready = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_pre_rvalid", {31'b0, rvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {22'b0, awready, wready, bvalid, bresp, arready, rvalid, rresp, irq},
          32'd0);
    check("arst_rdata", rdata, 32'd0);
    arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("arst_status", A_STAT, 32'd0);
    rd_chk("arst_first", A_FM, 32'hFFFF_FFFF);
    rd_chk("arst_ctrl", A_CTRL, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
